// File: rtl/pipe_fde_regs.sv
// pipe_fde_regs
//   Fetch/decode/execute pipeline register bank of the 5-stage MIPS core.
//   Holds the fetch PC, the F->D register (InstrD, PCPlus4D, ValidD) and the
//   D->E register (controls, operands, register fields, ValidE). It consumes
//   the hazard unit's StallF/StallD/FlushE and feeds rsE/rtE/WriteRegE/
//   RegWriteE/MemtoRegE back to it.
//
//   Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall/flush
//   performance counters (StallCnt, FlushCnt) and the CNT_W parameter.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   StallF, StallD, FlushE       hazard unit controls
//   PCSrcD                       branch taken in D, squashes the F->D load
//   PCNextF, InstrF, PCPlus4F    fetch-stage inputs
//   RegWriteD .. ALUControlD     decoded controls for the D-stage instruction
//   RD1D, RD2D, SignImmD         D-stage operands
//   PCF                          fetch PC
//   InstrD, PCPlus4D, ValidD     F->D register contents
//   rsD, rtD                     register fields of InstrD (combinational)
//   RegWriteE .. ALUControlE     E-stage controls
//   RD1E, RD2E, SignImmE         E-stage operands
//   rsE, rtE, rdE, ValidE        E-stage register fields / valid
//   WriteRegE                    E-stage destination (combinational)
//   StallCnt, FlushCnt           perf counters (PIPE_PERF_CNT_EN only)

module pipe_fde_regs #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned      CNT_W    = 16
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    // hazard unit controls
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             PCSrcD,
    // fetch stage
    input  logic [WIDTH-1:0] PCNextF,
    input  logic [WIDTH-1:0] InstrF,
    input  logic [WIDTH-1:0] PCPlus4F,
    // decode stage
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             MemWriteD,
    input  logic             ALUSrcD,
    input  logic             RegDstD,
    input  logic [2:0]       ALUControlD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] SignImmD,
    // outputs
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic [4:0]       rsD,
    output logic [4:0]       rtD,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic             MemWriteE,
    output logic             ALUSrcE,
    output logic             RegDstE,
    output logic [2:0]       ALUControlE,
    output logic [WIDTH-1:0] RD1E,
    output logic [WIDTH-1:0] RD2E,
    output logic [WIDTH-1:0] SignImmE,
    output logic [4:0]       rsE,
    output logic [4:0]       rtE,
    output logic [4:0]       rdE,
    output logic [4:0]       WriteRegE,
    output logic             ValidD,
    output logic             ValidE
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned ALU_W = 3;

    // E-stage control bundle
    typedef struct packed {
        logic             reg_write;
        logic             memto_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_dst;
        logic [ALU_W-1:0] alu_control;
    } ctrl_t;

    // state registers
    logic [WIDTH-1:0] pc_q, pc_n;
    logic [WIDTH-1:0] instr_d_q, instr_d_n;
    logic [WIDTH-1:0] pcplus4_d_q, pcplus4_d_n;
    logic             valid_d_q, valid_d_n;
    ctrl_t            ctrl_e_q, ctrl_e_n;
    logic [WIDTH-1:0] rd1_e_q, rd1_e_n;
    logic [WIDTH-1:0] rd2_e_q, rd2_e_n;
    logic [WIDTH-1:0] signimm_e_q, signimm_e_n;
    logic [REG_W-1:0] rs_e_q, rs_e_n;
    logic [REG_W-1:0] rt_e_q, rt_e_n;
    logic [REG_W-1:0] rd_e_q, rd_e_n;
    logic             valid_e_q, valid_e_n;

    // Decoded controls; write-side effects are masked for a squashed slot
    // since the decoder happily reports RegWrite=1 for the all-zero NOP.
    ctrl_t ctrl_d_c;
    always_comb begin
        ctrl_d_c             = '0;
        ctrl_d_c.reg_write   = RegWriteD & valid_d_q;
        ctrl_d_c.memto_reg   = MemtoRegD & valid_d_q;
        ctrl_d_c.mem_write   = MemWriteD & valid_d_q;
        ctrl_d_c.alu_src     = ALUSrcD;
        ctrl_d_c.reg_dst     = RegDstD;
        ctrl_d_c.alu_control = ALUControlD;
    end

    // Fetch PC next value
    always_comb begin
        pc_n = pc_q;
        if (!StallF) begin
            pc_n = PCNextF;
        end
    end

    // F->D next value: stall holds, taken branch squashes, otherwise load
    always_comb begin
        instr_d_n   = instr_d_q;
        pcplus4_d_n = pcplus4_d_q;
        valid_d_n   = valid_d_q;
        if (StallD) begin
            instr_d_n   = instr_d_q;
            pcplus4_d_n = pcplus4_d_q;
            valid_d_n   = valid_d_q;
        end else if (PCSrcD) begin
            instr_d_n   = '0;
            pcplus4_d_n = '0;
            valid_d_n   = 1'b0;
        end else begin
            instr_d_n   = InstrF;
            pcplus4_d_n = PCPlus4F;
            valid_d_n   = 1'b1;
        end
    end

    // D->E next value: flush inserts an all-zero bubble, otherwise load
    always_comb begin
        ctrl_e_n    = '0;
        rd1_e_n     = '0;
        rd2_e_n     = '0;
        signimm_e_n = '0;
        rs_e_n      = '0;
        rt_e_n      = '0;
        rd_e_n      = '0;
        valid_e_n   = 1'b0;
        if (!FlushE) begin
            ctrl_e_n    = ctrl_d_c;
            rd1_e_n     = RD1D;
            rd2_e_n     = RD2D;
            signimm_e_n = SignImmD;
            rs_e_n      = instr_d_q[25:21];
            rt_e_n      = instr_d_q[20:16];
            rd_e_n      = instr_d_q[15:11];
            valid_e_n   = valid_d_q;
        end
    end

    // Stage registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            instr_d_q   <= '0;
            pcplus4_d_q <= '0;
            valid_d_q   <= 1'b0;
            ctrl_e_q    <= '0;
            rd1_e_q     <= '0;
            rd2_e_q     <= '0;
            signimm_e_q <= '0;
            rs_e_q      <= '0;
            rt_e_q      <= '0;
            rd_e_q      <= '0;
            valid_e_q   <= 1'b0;
        end else begin
            pc_q        <= pc_n;
            instr_d_q   <= instr_d_n;
            pcplus4_d_q <= pcplus4_d_n;
            valid_d_q   <= valid_d_n;
            ctrl_e_q    <= ctrl_e_n;
            rd1_e_q     <= rd1_e_n;
            rd2_e_q     <= rd2_e_n;
            signimm_e_q <= signimm_e_n;
            rs_e_q      <= rs_e_n;
            rt_e_q      <= rt_e_n;
            rd_e_q      <= rd_e_n;
            valid_e_q   <= valid_e_n;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating stall/flush event counters
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             flush_ev_c;

    // a taken branch only squashes D when the stall is not holding it
    assign flush_ev_c = FlushE | (PCSrcD & ~StallD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallD && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_ev_c && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

    // Output mapping
    assign PCF         = pc_q;
    assign InstrD      = instr_d_q;
    assign PCPlus4D    = pcplus4_d_q;
    assign ValidD      = valid_d_q;
    assign rsD         = instr_d_q[25:21];
    assign rtD         = instr_d_q[20:16];

    assign RegWriteE   = ctrl_e_q.reg_write;
    assign MemtoRegE   = ctrl_e_q.memto_reg;
    assign MemWriteE   = ctrl_e_q.mem_write;
    assign ALUSrcE     = ctrl_e_q.alu_src;
    assign RegDstE     = ctrl_e_q.reg_dst;
    assign ALUControlE = ctrl_e_q.alu_control;
    assign RD1E        = rd1_e_q;
    assign RD2E        = rd2_e_q;
    assign SignImmE    = signimm_e_q;
    assign rsE         = rs_e_q;
    assign rtE         = rt_e_q;
    assign rdE         = rd_e_q;
    assign ValidE      = valid_e_q;

    // destination register selected by the E-stage RegDst
    assign WriteRegE   = ctrl_e_q.reg_dst ? rd_e_q : rt_e_q;

endmodule

// File: tb/tb_pipe_fde_regs.sv
// Directed testbench for pipe_fde_regs: reset, straight-line flow, load-use
// stall, taken branch, stall+branch, flush-only, reset mid-stall and (with
// PIPE_PERF_CNT_EN) counter saturation at CNT_W=4.

module tb_pipe_fde_regs;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        reset_n;
    logic        StallF, StallD, FlushE, PCSrcD;
    logic [31:0] PCNextF, InstrF, PCPlus4F;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, SignImmD;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic [4:0]  rsD, rtD;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE;
    logic [4:0]  rsE, rtE, rdE, WriteRegE;
    logic        ValidD, ValidE;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0]  StallCnt, FlushCnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_fde_regs #(
        .WIDTH(32),
        .RESET_PC(RESET_PC)
`ifdef PIPE_PERF_CNT_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .PCSrcD(PCSrcD),
        .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .rsD(rsD), .rtD(rtD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .WriteRegE(WriteRegE),
        .ValidD(ValidD), .ValidE(ValidE)
`ifdef PIPE_PERF_CNT_EN
        ,
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        StallF = 0; StallD = 0; FlushE = 0; PCSrcD = 0;
        PCNextF = 0; InstrF = 0; PCPlus4F = 0;
        RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; ALUSrcD = 0; RegDstD = 0;
        ALUControlD = 0; RD1D = 0; RD2D = 0; SignImmD = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        PCNextF = 32'h0000_1234;
        tick();
        tick();
        if (PCF !== RESET_PC) begin errors++; $display("FAIL reset_pcf got %h exp %h", PCF, RESET_PC); end checks++;
        if (InstrD !== 32'h0) begin errors++; $display("FAIL reset_instrd got %h exp 0", InstrD); end checks++;
        if (ValidD !== 1'b0 || ValidE !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b exp 00", ValidD, ValidE); end checks++;
        if (rsE !== 5'd0 || rtE !== 5'd0 || rdE !== 5'd0) begin errors++; $display("FAIL reset_regs got %0d %0d %0d exp 0", rsE, rtE, rdE); end checks++;
        if (RegWriteE !== 1'b0 || MemWriteE !== 1'b0) begin errors++; $display("FAIL reset_ctrl got %b%b exp 00", RegWriteE, MemWriteE); end checks++;
        reset_n = 1;
    endtask

    // add $8,$9,$10 flows F->D->E
    task automatic test_straight_line();
        PCNextF = 32'h4; PCPlus4F = 32'h4; InstrF = 32'h012A_4020;
        RegWriteD = 1; RegDstD = 1; ALUControlD = 3'b010;
        RD1D = 32'h1111_0009; RD2D = 32'h2222_000A; SignImmD = 32'h0000_4020;
        tick();
        if (PCF !== 32'h4) begin errors++; $display("FAIL sl_pcf got %h exp 4", PCF); end checks++;
        if (InstrD !== 32'h012A_4020 || ValidD !== 1'b1) begin errors++; $display("FAIL sl_instrd got %h/%b exp 012a4020/1", InstrD, ValidD); end checks++;
        if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL sl_pcplus4d got %h exp 4", PCPlus4D); end checks++;
        if (rsD !== 5'd9 || rtD !== 5'd10) begin errors++; $display("FAIL sl_rsd_rtd got %0d %0d exp 9 10", rsD, rtD); end checks++;
        // the reset bubble moved into E with RegWriteD=1 on the bus: must not write
        if (ValidE !== 1'b0 || RegWriteE !== 1'b0) begin errors++; $display("FAIL sl_bubble_e got %b%b exp 00", ValidE, RegWriteE); end checks++;
        tick();
        if (rsE !== 5'd9 || rtE !== 5'd10 || rdE !== 5'd8) begin errors++; $display("FAIL sl_regs_e got %0d %0d %0d exp 9 10 8", rsE, rtE, rdE); end checks++;
        if (RegDstE !== 1'b1 || WriteRegE !== 5'd8) begin errors++; $display("FAIL sl_writereg got %b/%0d exp 1/8", RegDstE, WriteRegE); end checks++;
        if (ValidE !== 1'b1 || RegWriteE !== 1'b1) begin errors++; $display("FAIL sl_valid_e got %b%b exp 11", ValidE, RegWriteE); end checks++;
        if (ALUControlE !== 3'b010 || RD1E !== 32'h1111_0009 || RD2E !== 32'h2222_000A || SignImmE !== 32'h0000_4020)
            begin errors++; $display("FAIL sl_operands got %b %h %h %h", ALUControlE, RD1E, RD2E, SignImmE); end checks++;
    endtask

    // lw $11,4($9) followed by a dependent add: one cycle of stall+bubble
    task automatic test_load_use();
        PCNextF = 32'h8; PCPlus4F = 32'h8; InstrF = 32'h8D2B_0004;
        tick();
        StallF = 1; StallD = 1; FlushE = 1;
        PCNextF = 32'hC; PCPlus4F = 32'hC; InstrF = 32'h016C_6820;
        tick();
        if (PCF !== 32'h8) begin errors++; $display("FAIL lu_pcf_hold got %h exp 8", PCF); end checks++;
        if (InstrD !== 32'h8D2B_0004 || ValidD !== 1'b1) begin errors++; $display("FAIL lu_instrd_hold got %h/%b exp 8d2b0004/1", InstrD, ValidD); end checks++;
        if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || rsE !== 5'd0 || rtE !== 5'd0)
            begin errors++; $display("FAIL lu_bubble got v%b w%b rs%0d rt%0d exp 0 0 0 0", ValidE, RegWriteE, rsE, rtE); end checks++;
        StallF = 0; StallD = 0; FlushE = 0;
        MemtoRegD = 1; RegDstD = 0; ALUSrcD = 1;
        tick();
        if (rsE !== 5'd9 || rtE !== 5'd11 || rdE !== 5'd0 || WriteRegE !== 5'd11)
            begin errors++; $display("FAIL lu_reenter got %0d %0d %0d wr%0d exp 9 11 0 11", rsE, rtE, rdE, WriteRegE); end checks++;
        if (ValidE !== 1'b1 || MemtoRegE !== 1'b1 || ALUSrcE !== 1'b1) begin errors++; $display("FAIL lu_ctrl_e got %b%b%b exp 111", ValidE, MemtoRegE, ALUSrcE); end checks++;
        if (InstrD !== 32'h016C_6820 || PCF !== 32'hC) begin errors++; $display("FAIL lu_advance got %h %h exp 016c6820 c", InstrD, PCF); end checks++;
    endtask

    // branch taken in D squashes the wrong-path fetch
    task automatic test_branch_taken();
        PCSrcD = 1; PCNextF = 32'h40; PCPlus4F = 32'h10; InstrF = 32'hDEAD_BEEF;
        MemWriteD = 1;
        tick();
        if (InstrD !== 32'h0 || ValidD !== 1'b0 || PCPlus4D !== 32'h0) begin errors++; $display("FAIL br_squash got %h/%b/%h exp 0/0/0", InstrD, ValidD, PCPlus4D); end checks++;
        if (PCF !== 32'h40) begin errors++; $display("FAIL br_pcf got %h exp 40", PCF); end checks++;
        if (rsE !== 5'd11 || rtE !== 5'd12 || rdE !== 5'd13) begin errors++; $display("FAIL br_e_regs got %0d %0d %0d exp 11 12 13", rsE, rtE, rdE); end checks++;
        PCSrcD = 0; PCNextF = 32'h44; PCPlus4F = 32'h44; InstrF = 32'h012A_4020;
        tick();
        // RegWriteD/MemtoRegD/MemWriteD are still 1 on the bus
        if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || MemtoRegE !== 1'b0 || MemWriteE !== 1'b0)
            begin errors++; $display("FAIL br_bubble_nowrite got v%b %b%b%b exp 0 000", ValidE, RegWriteE, MemtoRegE, MemWriteE); end checks++;
        if (rsE !== 5'd0 || rtE !== 5'd0) begin errors++; $display("FAIL br_bubble_regs got %0d %0d exp 0 0", rsE, rtE); end checks++;
        MemWriteD = 0;
    endtask

    // stall beats branch; squash happens once the stall releases
    task automatic test_stall_branch();
        StallF = 1; StallD = 1; PCSrcD = 1; PCNextF = 32'h80; InstrF = 32'hCAFE_F00D;
        tick();
        if (InstrD !== 32'h012A_4020 || ValidD !== 1'b1) begin errors++; $display("FAIL sb_hold got %h/%b exp 012a4020/1", InstrD, ValidD); end checks++;
        if (PCF !== 32'h44) begin errors++; $display("FAIL sb_pcf_hold got %h exp 44", PCF); end checks++;
        StallF = 0; StallD = 0;
        tick();
        if (InstrD !== 32'h0 || ValidD !== 1'b0) begin errors++; $display("FAIL sb_deferred_squash got %h/%b exp 0/0", InstrD, ValidD); end checks++;
        if (PCF !== 32'h80) begin errors++; $display("FAIL sb_pcf got %h exp 80", PCF); end checks++;
        PCSrcD = 0;
    endtask

    // FlushE alone: D loads, E gets a bubble
    task automatic test_flush_only();
        InstrF = 32'h012A_4020; PCNextF = 32'h84; PCPlus4F = 32'h84;
        tick();
        FlushE = 1; InstrF = 32'h8D2B_0004; PCNextF = 32'h88;
        tick();
        if (ValidE !== 1'b0 || rdE !== 5'd0 || RD1E !== 32'h0) begin errors++; $display("FAIL fo_bubble got v%b rd%0d %h exp 0 0 0", ValidE, rdE, RD1E); end checks++;
        if (InstrD !== 32'h8D2B_0004 || ValidD !== 1'b1) begin errors++; $display("FAIL fo_dload got %h/%b exp 8d2b0004/1", InstrD, ValidD); end checks++;
        FlushE = 0;
    endtask

    // reset asserted while stalled returns everything to reset state at once
    task automatic test_reset_mid_stall();
        StallF = 1; StallD = 1;
        tick();
        #2;
        reset_n = 0;
        #1;
        if (PCF !== RESET_PC || InstrD !== 32'h0) begin errors++; $display("FAIL rms_state got %h %h exp %h 0", PCF, InstrD, RESET_PC); end checks++;
        if (ValidD !== 1'b0 || ValidE !== 1'b0 || rsE !== 5'd0 || rtE !== 5'd0)
            begin errors++; $display("FAIL rms_valid got %b%b rs%0d rt%0d exp 00 0 0", ValidD, ValidE, rsE, rtE); end checks++;
        tick();
        reset_n = 1;
        StallF = 0; StallD = 0; PCNextF = 32'h200;
        tick();
        if (PCF !== 32'h200) begin errors++; $display("FAIL rms_resume got %h exp 200", PCF); end checks++;
    endtask

`ifdef PIPE_PERF_CNT_EN
    // StallCnt saturates at 15 with CNT_W=4; FlushCnt counts taken-branch squashes
    task automatic test_perf_cnt();
        clear_inputs();
        reset_n = 0;
        tick();
        reset_n = 1;
        StallD = 1;
        for (int i = 0; i < 5; i++) tick();
        if (StallCnt !== 4'd5) begin errors++; $display("FAIL pc_stall5 got %0d exp 5", StallCnt); end checks++;
        for (int i = 0; i < 15; i++) tick();
        if (StallCnt !== 4'd15) begin errors++; $display("FAIL pc_stall_sat got %0d exp 15", StallCnt); end checks++;
        tick();
        if (StallCnt !== 4'd15 || FlushCnt !== 4'd0) begin errors++; $display("FAIL pc_stall_hold got %0d/%0d exp 15/0", StallCnt, FlushCnt); end checks++;
        PCSrcD = 1;
        tick();
        if (FlushCnt !== 4'd0) begin errors++; $display("FAIL pc_branch_stalled got %0d exp 0", FlushCnt); end checks++;
        StallD = 0;
        for (int i = 0; i < 3; i++) tick();
        PCSrcD = 0; FlushE = 1;
        tick();
        if (FlushCnt !== 4'd4 || StallCnt !== 4'd15) begin errors++; $display("FAIL pc_flush got %0d/%0d exp 4/15", FlushCnt, StallCnt); end checks++;
        FlushE = 0;
        reset_n = 0;
        #1;
        if (StallCnt !== 4'd0 || FlushCnt !== 4'd0) begin errors++; $display("FAIL pc_reset got %0d/%0d exp 0/0", StallCnt, FlushCnt); end checks++;
        tick();
        reset_n = 1;
    endtask
`endif

    initial begin
        reset_n = 0;
        clear_inputs();
        test_reset();
        test_straight_line();
        test_load_use();
        test_branch_taken();
        test_stall_branch();
        test_flush_only();
        test_reset_mid_stall();
`ifdef PIPE_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
